vga_timing_gen: RTL

Parametrised VGA raster timing generator; successor to the team's fixed 640x480 sync generator. It provides configurable porch, sync and display geometry, programmable sync polarity, and a pixel-clock divider with a freeze enable. Sync and blank outputs are registered and exactly aligned to the coordinates they describe. Line and frame start strobes and a frame counter are also provided. It sits between the system clock and every pixel/sprite renderer, which consume `hpos`/`vpos` and the strobes.

---
 rtl/vga_timing_gen_if.sv | 25 ++
 rtl/vga_timing_gen.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus between the VGA timing generator and the pixel/sprite renderers.
// The generator drives position, sync, blank and strobes; consumers drive the run enable.
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          en;
  logic [CW-1:0] hpos;
  logic [CW-1:0] vpos;
  logic          hsync;
  logic          vsync;
  logic          display_on;
  logic          line_start;
  logic          frame_start;
  logic [7:0]    frame_count;

  modport master (
    input  en,
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count
  );

  modport slave (
    output en,
    input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock divider and freeze enable.
// Sync/blank are registered from the next counter values so they align with hpos/vpos.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 1,
  parameter int CW        = 10
) (
  input logic               clk,
  input logic               rst_n,
  vga_timing_gen_if.master  vif
);

  localparam int H_MAX    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int V_MAX    = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = H_DISPLAY + H_FRONT + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_BOTTOM;
  localparam int VS_END   = V_DISPLAY + V_BOTTOM + V_SYNC - 1;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] H_MAX_C    = CW'(H_MAX);
  localparam logic [CW-1:0] V_MAX_C    = CW'(V_MAX);
  localparam logic [CW-1:0] H_DISP_C   = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_DISP_C   = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_START_C = CW'(HS_START);
  localparam logic [CW-1:0] HS_END_C   = CW'(HS_END);
  localparam logic [CW-1:0] VS_START_C = CW'(VS_START);
  localparam logic [CW-1:0] VS_END_C   = CW'(VS_END);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic          HS_ACT     = (HSYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic          VS_ACT     = (VSYNC_POL != 0) ? 1'b1 : 1'b0;

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] hpos_q, hpos_d;
  logic [CW-1:0] vpos_q, vpos_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          display_on_q, display_on_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic          pe_s;
  logic          h_wrap_s;

  // Pixel tick generation; dropping en parks the divider at 0 so resume starts a fresh pixel.
  always_comb begin
    pe_s     = vif.en && (div_q == DIV_LAST);
    h_wrap_s = pe_s && (hpos_q == H_MAX_C);
    div_d    = div_q;
    if (!vif.en) begin
      div_d = '0;
    end else if (pe_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  // Raster position advance.
  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (h_wrap_s) begin
      hpos_d = '0;
      if (vpos_q == V_MAX_C) begin
        vpos_d = '0;
      end else begin
        vpos_d = vpos_q + CW'(1);
      end
    end else if (pe_s) begin
      hpos_d = hpos_q + CW'(1);
    end else begin
      hpos_d = hpos_q;
      vpos_d = vpos_q;
    end
  end

  // Decode from the upcoming position so the registered outputs match the position they accompany.
  always_comb begin
    hsync_d = ~HS_ACT;
    vsync_d = ~VS_ACT;
    if ((hpos_d >= HS_START_C) && (hpos_d <= HS_END_C)) begin
      hsync_d = HS_ACT;
    end else begin
      hsync_d = ~HS_ACT;
    end
    if ((vpos_d >= VS_START_C) && (vpos_d <= VS_END_C)) begin
      vsync_d = VS_ACT;
    end else begin
      vsync_d = ~VS_ACT;
    end
    display_on_d = (hpos_d < H_DISP_C) && (vpos_d < V_DISP_C);
  end

  // Strobes fire only on a tick that wraps, so they are one system clock wide at any divide ratio.
  always_comb begin
    line_start_d  = h_wrap_s;
    frame_start_d = h_wrap_s && (vpos_q == V_MAX_C);
    frame_count_d = frame_count_q;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 8'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      display_on_q  <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      div_q         <= div_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vif.hpos        = hpos_q;
  assign vif.vpos        = vpos_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.display_on  = display_on_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.frame_count = frame_count_q;

endmodule
